irs2_speed_servo: RTL and testbench

Closed-loop IRS2 sampling-speed servo downstream of `irs2_sample_mon`. It periodically requests a TSA→TSAOUT phase measurement and compares the 8-bit result to a programmed target. It then steps the Vdly DAC code toward the target through a load/ack handshake to the DAC writer. It also reports a lock status to the register block.

---
 rtl/irs2_speed_servo_pkg.sv | 23 ++
 rtl/irs2_servo_step.sv | 52 +++++
 rtl/irs2_speed_servo.sv | 190 +++++++++++++++++++
 tb/tb_irs2_speed_servo.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irs2_speed_servo_pkg.sv
// Shared constants and types for the IRS2 sampling-speed servo and its register block.
package irs2_speed_servo_pkg;

    localparam int unsigned ERR_W  = 8;
    localparam int unsigned VDLY_W = 16;

    localparam logic [VDLY_W-1:0] VDLY_INIT_DEF = 16'h0B00;
    localparam logic [VDLY_W-1:0] VDLY_MIN_DEF  = 16'h0400;
    localparam logic [VDLY_W-1:0] VDLY_MAX_DEF  = 16'hF000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_INTERVAL,
        ST_START,
        ST_WAIT_MEAS,
        ST_COMPUTE,
        ST_LOAD,
        ST_WAIT_ACK
    } state_t;

    typedef logic signed [ERR_W-1:0] err_t;

endpackage

// File: rtl/irs2_servo_step.sv
// Combinational servo step: wrapped phase error, deadband test and clamped next Vdly code.
module irs2_servo_step
    import irs2_speed_servo_pkg::*;
#(
    parameter int unsigned       GAIN_SHIFT = 2,
    parameter int unsigned       DEADBAND   = 1,
    parameter logic [VDLY_W-1:0] VDLY_MIN   = VDLY_MIN_DEF,
    parameter logic [VDLY_W-1:0] VDLY_MAX   = VDLY_MAX_DEF
) (
    input  logic [ERR_W-1:0]  phase,
    input  logic [ERR_W-1:0]  target,
    input  logic [VDLY_W-1:0] vdly,
    output err_t              err,
    output logic              in_deadband,
    output logic [VDLY_W-1:0] vdly_next
);

    localparam int unsigned SUM_W = VDLY_W + 1;

    logic signed [ERR_W:0]   err_ext;
    logic [ERR_W:0]          err_mag;
    err_t                    step;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] lo;
    logic signed [SUM_W-1:0] hi;

    always_comb begin
        // Modulo-256 difference read as two's complement handles the phase wrap.
        err         = $signed(ERR_W'(phase - target));
        err_ext     = {err[ERR_W-1], err};
        err_mag     = err_ext[ERR_W] ? -err_ext : err_ext;
        in_deadband = (err_mag <= (ERR_W+1)'(DEADBAND));

        step = err >>> GAIN_SHIFT;
        if (step == '0) begin
            step = err[ERR_W-1] ? '1 : ERR_W'(1);
        end

        lo  = $signed({1'b0, VDLY_MIN});
        hi  = $signed({1'b0, VDLY_MAX});
        sum = $signed({1'b0, vdly}) - $signed({{(SUM_W-ERR_W){step[ERR_W-1]}}, step});

        if (sum < lo) begin
            vdly_next = VDLY_MIN;
        end else if (sum > hi) begin
            vdly_next = VDLY_MAX;
        end else begin
            vdly_next = sum[VDLY_W-1:0];
        end
    end

endmodule

// File: rtl/irs2_speed_servo.sv
// Closed-loop IRS2 sampling-speed servo: periodic phase measurement, Vdly stepping
// through a load/ack handshake, and lock/timeout reporting.
module irs2_speed_servo
    import irs2_speed_servo_pkg::*;
#(
    parameter logic [15:0]       INTERVAL   = 16'd50000,
    parameter logic [15:0]       TIMEOUT    = 16'd65535,
    parameter logic [VDLY_W-1:0] VDLY_INIT  = VDLY_INIT_DEF,
    parameter logic [VDLY_W-1:0] VDLY_MIN   = VDLY_MIN_DEF,
    parameter logic [VDLY_W-1:0] VDLY_MAX   = VDLY_MAX_DEF,
    parameter int unsigned       GAIN_SHIFT = 2,
    parameter int unsigned       DEADBAND   = 1,
    parameter int unsigned       LOCK_COUNT = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              present_i,
    input  logic              servo_enable_i,
    input  logic [ERR_W-1:0]  target_phase_i,
    output logic              mon_enable_o,
    input  logic [ERR_W-1:0]  phase_i,
    input  logic              phase_done_i,
    output logic [VDLY_W-1:0] vdly_o,
    output logic              vdly_load_o,
    input  logic              vdly_ack_i,
    output logic [ERR_W-1:0]  err_o,
    output logic              locked_o,
    output logic              timeout_o
);

    localparam int unsigned LOCK_W = 8;

    state_t              state;
    state_t              state_d;
    logic [15:0]         ivl_cnt;
    logic [15:0]         ivl_cnt_d;
    logic [15:0]         tmo_cnt;
    logic [15:0]         tmo_cnt_d;
    logic [LOCK_W-1:0]   lock_cnt;
    logic [LOCK_W-1:0]   lock_cnt_d;
    logic [ERR_W-1:0]    phase_q;
    logic [ERR_W-1:0]    phase_d;
    logic [VDLY_W-1:0]   vdly_d;
    logic [ERR_W-1:0]    err_d;
    logic                mon_enable_d;
    logic                vdly_load_d;
    logic                locked_d;
    logic                timeout_d;

    logic [ERR_W-1:0]    step_phase;
    err_t                step_err;
    logic                step_db;
    logic [VDLY_W-1:0]   step_vdly;

    // Live phase on the completion cycle so err_o is valid one cycle after phase_done_i.
    assign step_phase = (state == ST_WAIT_MEAS) ? phase_i : phase_q;

    irs2_servo_step #(
        .GAIN_SHIFT (GAIN_SHIFT),
        .DEADBAND   (DEADBAND),
        .VDLY_MIN   (VDLY_MIN),
        .VDLY_MAX   (VDLY_MAX)
    ) u_step (
        .phase       (step_phase),
        .target      (target_phase_i),
        .vdly        (vdly_o),
        .err         (step_err),
        .in_deadband (step_db),
        .vdly_next   (step_vdly)
    );

    always_comb begin
        state_d    = state;
        ivl_cnt_d  = ivl_cnt;
        tmo_cnt_d  = tmo_cnt;
        lock_cnt_d = lock_cnt;
        phase_d    = phase_q;
        vdly_d     = vdly_o;
        err_d      = err_o;
        timeout_d  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (present_i && servo_enable_i) begin
                    state_d = ST_LOAD;
                    vdly_d  = VDLY_INIT;
                end
            end
            ST_WAIT_INTERVAL: begin
                if (!servo_enable_i) begin
                    state_d = ST_IDLE;
                end else if (ivl_cnt == 16'd0) begin
                    state_d = ST_START;
                end else begin
                    ivl_cnt_d = ivl_cnt - 16'd1;
                end
            end
            ST_START: begin
                if (!servo_enable_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_WAIT_MEAS;
                    tmo_cnt_d = 16'd0;
                end
            end
            ST_WAIT_MEAS: begin
                if (!servo_enable_i) begin
                    state_d = ST_IDLE;
                end else if (phase_done_i) begin
                    phase_d = phase_i;
                    err_d   = step_err;
                    state_d = ST_COMPUTE;
                end else if (tmo_cnt == TIMEOUT - 16'd1) begin
                    state_d   = ST_WAIT_INTERVAL;
                    timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt + 16'd1;
                end
            end
            ST_COMPUTE: begin
                if (step_db) begin
                    if (lock_cnt < LOCK_W'(LOCK_COUNT)) begin
                        lock_cnt_d = lock_cnt + LOCK_W'(1);
                    end
                    state_d = ST_WAIT_INTERVAL;
                end else begin
                    lock_cnt_d = '0;
                    vdly_d     = step_vdly;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD, ST_WAIT_ACK: begin
                state_d = vdly_ack_i ? ST_WAIT_INTERVAL : ST_WAIT_ACK;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_WAIT_INTERVAL && state != ST_WAIT_INTERVAL) begin
            ivl_cnt_d = INTERVAL - 16'd1;
        end
        if (state_d == ST_IDLE) begin
            lock_cnt_d = '0;
        end

        // Board removal aborts everything, including a pending DAC handshake; Vdly is held.
        if (!present_i) begin
            state_d    = ST_IDLE;
            lock_cnt_d = '0;
            vdly_d     = vdly_o;
            err_d      = err_o;
            phase_d    = phase_q;
            timeout_d  = 1'b0;
        end

        mon_enable_d = (state_d == ST_START);
        vdly_load_d  = (state_d == ST_LOAD) || (state_d == ST_WAIT_ACK);
        locked_d     = (lock_cnt_d == LOCK_W'(LOCK_COUNT));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state        <= ST_IDLE;
            ivl_cnt      <= 16'd0;
            tmo_cnt      <= 16'd0;
            lock_cnt     <= '0;
            phase_q      <= '0;
            vdly_o       <= VDLY_INIT;
            err_o        <= '0;
            mon_enable_o <= 1'b0;
            vdly_load_o  <= 1'b0;
            locked_o     <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            state        <= state_d;
            ivl_cnt      <= ivl_cnt_d;
            tmo_cnt      <= tmo_cnt_d;
            lock_cnt     <= lock_cnt_d;
            phase_q      <= phase_d;
            vdly_o       <= vdly_d;
            err_o        <= err_d;
            mon_enable_o <= mon_enable_d;
            vdly_load_o  <= vdly_load_d;
            locked_o     <= locked_d;
            timeout_o    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_irs2_speed_servo.sv
// Self-checking bench for irs2_speed_servo: spec vectors, clamp ramps, random stimulus
// against an arithmetic reference model, timeout and board-removal sequences.
module tb_irs2_speed_servo;

    localparam int VINIT = 'h0B00;
    localparam int VMIN  = 'h0400;
    localparam int VMAX  = 'hF000;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        present_i;
    logic        servo_enable_i;
    logic [7:0]  target_phase_i;
    logic        mon_enable_o;
    logic [7:0]  phase_i;
    logic        phase_done_i;
    logic [15:0] vdly_o;
    logic        vdly_load_o;
    logic        vdly_ack_i;
    logic [7:0]  err_o;
    logic        locked_o;
    logic        timeout_o;

    int n_checks = 0;
    int n_pass   = 0;
    int m_vdly;
    int m_lock;

    typedef struct {
        logic [7:0]  tgt;
        logic [7:0]  ph;
        int          err;
        logic [15:0] vdly;
        logic        load;
        logic        locked;
    } vec_t;

    vec_t vecs [9];

    irs2_speed_servo #(
        .INTERVAL (16'd10),
        .TIMEOUT  (16'd100)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .present_i      (present_i),
        .servo_enable_i (servo_enable_i),
        .target_phase_i (target_phase_i),
        .mon_enable_o   (mon_enable_o),
        .phase_i        (phase_i),
        .phase_done_i   (phase_done_i),
        .vdly_o         (vdly_o),
        .vdly_load_o    (vdly_load_o),
        .vdly_ack_i     (vdly_ack_i),
        .err_o          (err_o),
        .locked_o       (locked_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    endtask

    // Phase difference taken modulo 256 and folded into -128..127.
    function automatic int wrap_err(input logic [7:0] ph, input logic [7:0] tgt);
        int e;
        e = (int'(ph) - int'(tgt) + 256) % 256;
        if (e > 127) e -= 256;
        return e;
    endfunction

    task automatic model_step(input int e, output bit load);
        int step;
        if (e >= -1 && e <= 1) begin
            if (m_lock < 4) m_lock++;
            load = 1'b0;
        end else begin
            m_lock = 0;
            step = (e >= 0) ? e / 4 : -((-e + 3) / 4);
            if (step == 0) step = (e > 0) ? 1 : -1;
            m_vdly = m_vdly - step;
            if (m_vdly < VMIN) m_vdly = VMIN;
            if (m_vdly > VMAX) m_vdly = VMAX;
            load = 1'b1;
        end
    endtask

    // One full measurement: answer the request, check err/load/vdly/lock, complete the handshake.
    task automatic measure(input logic [7:0] tgt, input logic [7:0] ph, input int dly,
                           input int ack_dly, output int g_err, output logic [15:0] g_vdly,
                           output logic g_load, output logic g_locked);
        int n;
        int e;
        bit exp_load;
        target_phase_i = tgt;
        n = 0;
        while (mon_enable_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("mon_enable_request", mon_enable_o, 1);
        @(negedge clk_i);
        check("mon_enable_single", mon_enable_o, 0);
        repeat (dly) @(negedge clk_i);
        phase_i      = ph;
        phase_done_i = 1'b1;
        @(negedge clk_i);
        phase_done_i = 1'b0;
        phase_i      = 8'($urandom);
        e = wrap_err(ph, tgt);
        model_step(e, exp_load);
        g_err = int'($signed(err_o));
        check("err_o", g_err, e);
        @(negedge clk_i);
        g_vdly   = vdly_o;
        g_load   = vdly_load_o;
        g_locked = locked_o;
        check("vdly_load_o", g_load, exp_load);
        check("vdly_o", g_vdly, m_vdly);
        check("locked_o", g_locked, (m_lock == 4));
        if (exp_load) begin
            repeat (ack_dly) @(negedge clk_i);
            check("vdly_load_held", vdly_load_o, 1);
            vdly_ack_i = 1'b1;
            @(negedge clk_i);
            vdly_ack_i = 1'b0;
            check("vdly_load_drop", vdly_load_o, 0);
            check("vdly_stable", vdly_o, m_vdly);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int n;
        int r;
        int g_err;
        logic [15:0] g_vdly;
        logic g_load;
        logic g_locked;
        logic [7:0] tgt;
        logic [7:0] ph;

        vecs[0] = '{tgt: 8'h40, ph: 8'h50, err: 16,   vdly: 16'h0AFC, load: 1'b1, locked: 1'b0};
        vecs[1] = '{tgt: 8'hFE, ph: 8'h02, err: 4,    vdly: 16'h0AFB, load: 1'b1, locked: 1'b0};
        vecs[2] = '{tgt: 8'h80, ph: 8'h81, err: 1,    vdly: 16'h0AFB, load: 1'b0, locked: 1'b0};
        vecs[3] = '{tgt: 8'h80, ph: 8'h7F, err: -1,   vdly: 16'h0AFB, load: 1'b0, locked: 1'b0};
        vecs[4] = '{tgt: 8'h33, ph: 8'h33, err: 0,    vdly: 16'h0AFB, load: 1'b0, locked: 1'b0};
        vecs[5] = '{tgt: 8'h10, ph: 8'h11, err: 1,    vdly: 16'h0AFB, load: 1'b0, locked: 1'b1};
        vecs[6] = '{tgt: 8'h10, ph: 8'h18, err: 8,    vdly: 16'h0AF9, load: 1'b1, locked: 1'b0};
        vecs[7] = '{tgt: 8'h10, ph: 8'h0E, err: -2,   vdly: 16'h0AFA, load: 1'b1, locked: 1'b0};
        vecs[8] = '{tgt: 8'h00, ph: 8'h80, err: -128, vdly: 16'h0B1A, load: 1'b1, locked: 1'b0};

        rst_n_i = 1'b0; present_i = 1'b1; servo_enable_i = 1'b1;
        target_phase_i = 8'h00; phase_i = 8'h00; phase_done_i = 1'b0; vdly_ack_i = 1'b0;
        m_vdly = VINIT; m_lock = 0;
        repeat (3) @(negedge clk_i);
        check("rst_mon_enable", mon_enable_o, 0);
        check("rst_vdly", vdly_o, 16'h0B00);
        check("rst_vdly_load", vdly_load_o, 0);
        check("rst_err", err_o, 0);
        check("rst_locked", locked_o, 0);
        check("rst_timeout", timeout_o, 0);

        // Enable: one push of the initial code, accepted on the cycle load rises.
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check("init_load", vdly_load_o, 1);
        check("init_vdly", vdly_o, 16'h0B00);
        vdly_ack_i = 1'b1;
        @(negedge clk_i);
        vdly_ack_i = 1'b0;
        check("init_load_drop", vdly_load_o, 0);
        n = 0;
        while (mon_enable_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("first_request_delay", n, 10);

        for (int i = 0; i < 9; i++) begin
            measure(vecs[i].tgt, vecs[i].ph, i % 3, i % 4, g_err, g_vdly, g_load, g_locked);
            check($sformatf("vec%0d_err", i), g_err, vecs[i].err);
            check($sformatf("vec%0d_vdly", i), g_vdly, vecs[i].vdly);
            check($sformatf("vec%0d_load", i), g_load, vecs[i].load);
            check($sformatf("vec%0d_locked", i), g_locked, vecs[i].locked);
        end

        // Walk down to 0x0402, then a +40 error must clamp at the minimum.
        while (m_vdly - 'h0402 >= 31) measure(8'h00, 8'd127, 0, 0, g_err, g_vdly, g_load, g_locked);
        r = m_vdly - 'h0402;
        if (r > 0) measure(8'h00, 8'(4 * r), 0, 0, g_err, g_vdly, g_load, g_locked);
        check("ramp_low_vdly", vdly_o, 16'h0402);
        measure(8'h00, 8'd40, 1, 1, g_err, g_vdly, g_load, g_locked);
        check("clamp_min_err", g_err, 40);
        check("clamp_min_vdly", g_vdly, 16'h0400);

        // Walk up to 0xEFF0, then a -128 error must clamp at the maximum.
        while ('hEFF0 - m_vdly >= 32) measure(8'h00, 8'h80, 0, 0, g_err, g_vdly, g_load, g_locked);
        r = 'hEFF0 - m_vdly;
        if (r > 0) measure(8'h00, 8'(256 - 4 * r), 0, 0, g_err, g_vdly, g_load, g_locked);
        check("ramp_high_vdly", vdly_o, 16'hEFF0);
        measure(8'h00, 8'h80, 2, 2, g_err, g_vdly, g_load, g_locked);
        check("clamp_max_err", g_err, -128);
        check("clamp_max_vdly", g_vdly, 16'hF000);

        // Random measurements with stray completion pulses outside the measurement window.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                phase_i      = 8'($urandom);
                phase_done_i = 1'b1;
                @(negedge clk_i);
                phase_done_i = 1'b0;
            end
            tgt = 8'($urandom);
            if ($urandom_range(0, 1) == 0) ph = tgt + 8'($urandom_range(0, 6)) - 8'd3;
            else ph = 8'($urandom);
            measure(tgt, ph, $urandom_range(0, 5), $urandom_range(0, 3), g_err, g_vdly, g_load, g_locked);
        end

        // Lock, then a missing completion must time out without touching lock.
        for (int i = 0; i < 4; i++) measure(8'h55, 8'h55, 0, 0, g_err, g_vdly, g_load, g_locked);
        check("lock_before_timeout", locked_o, 1);
        n = 0;
        while (mon_enable_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("timeout_request", mon_enable_o, 1);
        n = 0;
        while (timeout_o !== 1'b1 && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        check("timeout_cycle", n, 101);
        check("timeout_lock_kept", locked_o, 1);
        @(negedge clk_i);
        n = 1;
        check("timeout_single", timeout_o, 0);
        while (mon_enable_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("restart_after_timeout", n, 10);

        // Board removed in the middle of a DAC handshake.
        target_phase_i = 8'h00;
        @(negedge clk_i);
        phase_i      = 8'h20;
        phase_done_i = 1'b1;
        @(negedge clk_i);
        phase_done_i = 1'b0;
        m_lock = 0;
        m_vdly = m_vdly - 8;
        @(negedge clk_i);
        check("pd_load_rise", vdly_load_o, 1);
        @(negedge clk_i);
        check("pd_load_held", vdly_load_o, 1);
        present_i = 1'b0;
        @(negedge clk_i);
        check("pd_load_dropped", vdly_load_o, 0);
        check("pd_locked", locked_o, 0);
        check("pd_vdly_held", vdly_o, m_vdly);
        repeat (3) @(negedge clk_i);
        check("pd_idle_quiet", vdly_load_o | mon_enable_o, 0);
        present_i = 1'b1;
        @(negedge clk_i);
        check("reinit_load", vdly_load_o, 1);
        check("reinit_vdly", vdly_o, 16'h0B00);
        m_vdly = VINIT;
        vdly_ack_i = 1'b1;
        @(negedge clk_i);
        vdly_ack_i = 1'b0;
        measure(8'h40, 8'h50, 1, 0, g_err, g_vdly, g_load, g_locked);
        check("reinit_step_vdly", g_vdly, 16'h0AFC);

        // Disabling the servo stops measurement requests.
        servo_enable_i = 1'b0;
        n = 0;
        repeat (30) begin
            @(negedge clk_i);
            if (mon_enable_o) n++;
        end
        check("disabled_requests", n, 0);
        check("disabled_load", vdly_load_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
